// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the byte-wide RAM port between icache fills
// and the load/store buffer, serialising each transfer into byte accesses.
module mem_arbiter #(
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    ic_req,
  input  logic [31:0]             ic_addr,
  output logic                    ic_done,
  output logic [LINE_BYTES*8-1:0] ic_data,
  input  logic                    ls_req,
  input  logic                    ls_wr,
  input  logic [31:0]             ls_addr,
  input  logic [1:0]              ls_size,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_done,
  output logic [31:0]             ls_rdata,
  input  logic                    clear
);

  localparam int CW = $clog2(LINE_BYTES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FINISH
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             base_q, base_d;
  logic [CW-1:0]           n_q, n_d;
  logic [CW-1:0]           i_q, i_d;
  logic [CW-1:0]           c_q, c_d;
  logic                    pend_q, pend_d;
  logic                    wr_q, wr_d;
  logic                    gnt_ls_q, gnt_ls_d;
  logic                    last_ls_q, last_ls_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             a_hold_q, a_hold_d;
  logic [LINE_BYTES*8-1:0] ic_data_q, ic_data_d;
  logic [31:0]             ls_rdata_q, ls_rdata_d;

  logic [31:0]   mem_a_c;
  logic          wr_c;
  logic          pick_ls;
  logic          pick_ic;
  logic [CW-1:0] ls_n;

  always_comb begin
    unique case (ls_size)
      2'd0:    ls_n = CW'(1);
      2'd1:    ls_n = CW'(2);
      default: ls_n = CW'(4);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    n_d        = n_q;
    i_d        = i_q;
    c_d        = c_q;
    pend_d     = pend_q;
    wr_d       = wr_q;
    gnt_ls_d   = gnt_ls_q;
    last_ls_d  = last_ls_q;
    wdata_d    = wdata_q;
    ic_data_d  = ic_data_q;
    ls_rdata_d = ls_rdata_q;
    mem_a_c    = '0;
    mem_dout   = '0;
    wr_c       = 1'b0;
    ic_done    = 1'b0;
    ls_done    = 1'b0;
    pick_ls    = ls_req & (~ic_req | ~last_ls_q);
    pick_ic    = ic_req & ~pick_ls;

    if (rdy_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (!clear && (pick_ls || pick_ic)) begin
            base_d   = pick_ls ? ls_addr : ic_addr;
            n_d      = pick_ls ? ls_n : CW'(LINE_BYTES);
            wr_d     = pick_ls & ls_wr;
            gnt_ls_d = pick_ls;
            wdata_d  = ls_wdata;
            i_d      = '0;
            c_d      = '0;
            pend_d   = 1'b0;
            state_d  = (pick_ls && ls_wr) ? S_WRITE : S_READ;
            if (pick_ls && !ls_wr) ls_rdata_d = '0;
          end
        end
        S_READ: begin
          if (clear) begin
            state_d = S_IDLE;
            i_d     = '0;
            c_d     = '0;
            pend_d  = 1'b0;
          end else begin
            pend_d = (i_q < n_q);
            if (i_q < n_q) begin
              mem_a_c = base_q + 32'(i_q);
              i_d     = i_q + CW'(1);
            end
            if (pend_q) begin
              if (gnt_ls_q)
                ls_rdata_d[{c_q[1:0], 3'b000} +: 8] = mem_din;
              else
                ic_data_d[{c_q[CW-2:0], 3'b000} +: 8] = mem_din;
              c_d = c_q + CW'(1);
              if (c_q == n_q - CW'(1)) state_d = S_FINISH;
            end
          end
        end
        S_WRITE: begin
          mem_a_c  = base_q + 32'(i_q);
          mem_dout = wdata_q[{i_q[1:0], 3'b000} +: 8];
          wr_c     = 1'b1;
          i_d      = i_q + CW'(1);
          if (i_q == n_q - CW'(1)) state_d = S_FINISH;
        end
        S_FINISH: begin
          state_d = S_IDLE;
          i_d     = '0;
          c_d     = '0;
          pend_d  = 1'b0;
          // an aborted read gives no done and does not count as a grant
          if (!(clear && !wr_q)) begin
            ic_done   = ~gnt_ls_q;
            ls_done   = gnt_ls_q;
            last_ls_d = gnt_ls_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_READ) begin
      // the byte in flight is lost; reissue from the capture pointer
      i_d    = c_q;
      pend_d = 1'b0;
    end

    mem_a    = rdy_in ? mem_a_c : a_hold_q;
    mem_wr   = rdy_in & wr_c;
    a_hold_d = mem_a;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      n_q        <= '0;
      i_q        <= '0;
      c_q        <= '0;
      pend_q     <= 1'b0;
      wr_q       <= 1'b0;
      gnt_ls_q   <= 1'b0;
      last_ls_q  <= 1'b0;
      wdata_q    <= '0;
      a_hold_q   <= '0;
      ic_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      n_q        <= n_d;
      i_q        <= i_d;
      c_q        <= c_d;
      pend_q     <= pend_d;
      wr_q       <= wr_d;
      gnt_ls_q   <= gnt_ls_d;
      last_ls_q  <= last_ls_d;
      wdata_q    <= wdata_d;
      a_hold_q   <= a_hold_d;
      ic_data_q  <= ic_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign ic_data  = ic_data_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         rdy_in;
  logic [7:0]   mem_din;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic         ic_done;
  logic [127:0] ic_data;
  logic         ls_req;
  logic         ls_wr;
  logic [31:0]  ls_addr;
  logic [1:0]   ls_size;
  logic [31:0]  ls_wdata;
  logic         ls_done;
  logic [31:0]  ls_rdata;
  logic         clear;

  mem_arbiter #(.LINE_BYTES(16)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_done  (ic_done),
    .ic_data  (ic_data),
    .ls_req   (ls_req),
    .ls_wr    (ls_wr),
    .ls_addr  (ls_addr),
    .ls_size  (ls_size),
    .ls_wdata (ls_wdata),
    .ls_done  (ls_done),
    .ls_rdata (ls_rdata),
    .clear    (clear)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram [int unsigned];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if ($isunknown(a)) return 8'h00;
    if (ram.exists(a)) return ram[a];
    return a[7:0];
  endfunction

  always @(posedge clk_in) begin
    if (mem_wr === 1'b1 && !$isunknown(mem_a)) ram[mem_a] = mem_dout;
    mem_din <= rd(mem_a);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  logic [31:0] tr_a    [0:63];
  logic        tr_wr   [0:63];
  logic [7:0]  tr_dout [0:63];
  int          done_cyc;
  logic        other_seen;

  // called in cycle 0 (grant cycle); cycle k is k edges later
  task automatic xfer(input bit is_ls, input int clr_at,
                      input int pause_at);
    done_cyc   = -1;
    other_seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      tr_a[k]    = mem_a;
      tr_wr[k]   = mem_wr;
      tr_dout[k] = mem_dout;
      if (is_ls ? ic_done : ls_done) other_seen = 1'b1;
      if (k == clr_at) clear = 1'b1;
      else if (k == clr_at + 1) clear = 1'b0;
      if (k == pause_at) rdy_in = 1'b0;
      else if (k == pause_at + 3) rdy_in = 1'b1;
      if (is_ls ? ls_done : ic_done) begin
        done_cyc = k;
        if (is_ls) ls_req = 1'b0;
        else ic_req = 1'b0;
        clear  = 1'b0;
        rdy_in = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_chk(input string tag);
    step();
    check({tag, "_a"}, mem_a, 32'h0);
    check({tag, "_wr"}, mem_wr, 1'b0);
  endtask

  task automatic set_ls(input logic wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd);
    ls_wr    = wr;
    ls_addr  = a;
    ls_size  = sz;
    ls_wdata = wd;
    ls_req   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ram[32'h100] = 8'h11;
    ram[32'h101] = 8'h22;
    ram[32'h102] = 8'h33;
    ram[32'h103] = 8'h44;
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    clear    = 1'b0;
    ic_req   = 1'b0;
    ic_addr  = '0;
    ls_req   = 1'b0;
    ls_wr    = 1'b0;
    ls_addr  = '0;
    ls_size  = '0;
    ls_wdata = '0;
    repeat (3) step();
    check("rst_a", mem_a, 32'h0);
    check("rst_wr", mem_wr, 1'b0);
    check("rst_dout", mem_dout, 8'h0);
    check("rst_done", {ic_done, ls_done}, 2'b00);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    check("rst_ic_data", ic_data, 128'h0);

    // both requests from reset: LSB wins the first tie
    rst_in  = 1'b0;
    ic_req  = 1'b1;
    ic_addr = 32'h1000;
    set_ls(1'b0, 32'h100, 2'd2, 32'h0);
    xfer(1'b1, 0, 0);
    check("ld_cyc", done_cyc, 6);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("ld_a%0d", j), tr_a[j+1], 32'h100 + j);
      check($sformatf("ld_wr%0d", j), tr_wr[j+1], 1'b0);
    end
    check("ld_data", ls_rdata, 32'h44332211);
    check("ld_no_ic", other_seen, 1'b0);
    idle_chk("idle1");
    set_ls(1'b1, 32'h2001, 2'd1, 32'h0000BEEF);

    xfer(1'b0, 0, 0);
    check("ic_cyc", done_cyc, 18);
    for (int j = 0; j < 16; j++)
      check($sformatf("ic_a%0d", j), tr_a[j+1], 32'h1000 + j);
    check("ic_data", ic_data, 128'h0F0E0D0C0B0A09080706050403020100);
    check("ic_no_ls", other_seen, 1'b0);
    idle_chk("idle2");
    ic_req  = 1'b1;
    ic_addr = 32'h1010;

    xfer(1'b1, 0, 0);
    check("hs_cyc", done_cyc, 3);
    check("hs_a1", tr_a[1], 32'h2001);
    check("hs_d1", tr_dout[1], 8'hEF);
    check("hs_w1", tr_wr[1], 1'b1);
    check("hs_a2", tr_a[2], 32'h2002);
    check("hs_d2", tr_dout[2], 8'hBE);
    check("hs_w2", tr_wr[2], 1'b1);
    check("hs_ram", {rd(32'h2002), rd(32'h2001)}, 16'hBEEF);
    idle_chk("idle3");

    xfer(1'b0, 0, 0);
    check("ic2_cyc", done_cyc, 18);
    check("ic2_data", ic_data, 128'h1F1E1D1C1B1A19181716151413121110);
    idle_chk("idle4");
    ic_req  = 1'b1;
    ic_addr = 32'h1020;

    // mispredict in cycle 8 of a fill; the pending load goes next
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 3) set_ls(1'b0, 32'h104, 2'd2, 32'h0);
      if (k == 8) begin
        check("clr_a8", mem_a, 32'h1027);
        check("clr_done8", ic_done, 1'b0);
        clear  = 1'b1;
        ic_req = 1'b0;
      end
    end
    step();
    check("clr_idle_a", mem_a, 32'h0);
    check("clr_idle_done", {ic_done, ls_done}, 2'b00);
    clear = 1'b0;
    xfer(1'b1, 0, 0);
    check("clr_ld_cyc", done_cyc, 6);
    check("clr_ld_a1", tr_a[1], 32'h104);
    check("clr_ld_data", ls_rdata, 32'h07060504);
    check("clr_no_ic", other_seen, 1'b0);
    idle_chk("idle5");

    // a clear never cuts a store short
    set_ls(1'b1, 32'h3000, 2'd2, 32'hA1B2C3D4);
    xfer(1'b1, 2, 0);
    check("sw_cyc", done_cyc, 5);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("sw_a%0d", j), tr_a[j+1], 32'h3000 + j);
      check($sformatf("sw_w%0d", j), tr_wr[j+1], 1'b1);
    end
    check("sw_d0", tr_dout[1], 8'hD4);
    check("sw_d3", tr_dout[4], 8'hA1);
    check("sw_ram",
          {rd(32'h3003), rd(32'h3002), rd(32'h3001), rd(32'h3000)},
          32'hA1B2C3D4);
    idle_chk("idle6");

    // three-cycle pause right after the first byte is issued
    set_ls(1'b0, 32'h1A4, 2'd2, 32'h0);
    xfer(1'b1, 0, 2);
    check("ps_cyc", done_cyc, 10);
    for (int k = 3; k <= 5; k++) begin
      check($sformatf("ps_a%0d", k), tr_a[k], 32'h1A4);
      check($sformatf("ps_w%0d", k), tr_wr[k], 1'b0);
    end
    check("ps_data", ls_rdata, 32'hA7A6A5A4);
    idle_chk("idle7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
